aoi_sweep_controller: RTL
=========================

# aoi_sweep_controller

Sequencer that exhaustively exercises an external 4-input and-or-invert gate (and_or_invert_4inputs, out = ~((a&b)|(c&d))). It drives all 16 input vectors in ascending order and waits a programmable settle time per vector. It samples the gate output, compares it against a built-in golden function, and reports pass/fail, the mismatch count and the first failing vector. It sits beside the AOI/full-adder datapath as a built-in self-test controller, started by a one-cycle request.

## Interface
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request; honoured only in IDLE.
- aoi_out  input  1  output of the gate under test.
- aoi_a, aoi_b, aoi_c, aoi_d  output  1 each  vector bits to the gate: a=vec[3], b=vec[2], c=vec[1], d=vec[0].
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  err_count==0 for the last completed sweep; held until the next start.
- err_count  output  5  mismatches in the current/last sweep, 0..16, saturates at 16.
- fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  4  vec of the first mismatch; 0 when fail_valid=0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE; 2-bit encoding.
- IDLE: start=1 clears vec, wait_cnt, err_count, fail_valid, first_fail_vec and pass, then goes to SETTLE.
- SETTLE: wait_cnt increments each cycle. When wait_cnt==SETTLE_CYCLES-1, the FSM clears wait_cnt and goes to SAMPLE.
- SAMPLE: the block compares aoi_out to golden(vec) = ~((vec[3]&vec[2])|(vec[1]&vec[0])).
  - On mismatch, err_count increments. If fail_valid=0, first_fail_vec<=vec and fail_valid<=1.
  - If vec==15, go to DONE. Otherwise vec<=vec+1 and return to SETTLE.
  - vec never wraps within a sweep.
- DONE: done=1 for exactly one cycle; pass<=(err_count==0) after the final comparison is included; then IDLE.
- aoi_a..d are driven directly from the vec register: glitch-free and stable for the whole SETTLE+SAMPLE window.
- busy=1 in SETTLE, SAMPLE and DONE.
- start while busy is ignored. Start is not queued.
- Reset at any point, including mid-sweep, returns the block to IDLE with every output 0 and vec=0.
- After reset, pass=0 until the first completed sweep.

## Timing
- Edge E0 samples start=1. The FSM is in SETTLE for vector 0 after E0.
- Each vector takes SETTLE_CYCLES+1 cycles. Vector k is compared at edge (k+1)(SETTLE_CYCLES+1).
- With the default SETTLE_CYCLES=2:
  - Last compare at E48.
  - done high between E48 and E49; pass valid from E49.
  - busy falls at E49.
- err_count and first_fail_vec update at the compare edge and are visible the following cycle.
- No combinational path from aoi_out to any output.
- Reset values: aoi_a..d=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0.

## Structure
- Package aoi_ctrl_pkg contains:
  - state typedef/localparams (IDLE, SETTLE, SAMPLE, DONE);
  - VEC_COUNT=16;
  - aoi_golden function, shared with benches and any future full-adder sweep controller.
- One natural sub-module: aoi_sweep_counter, which holds vec and wait_cnt with clear/step/last-flag outputs.
- The FSM and the scoreboard registers stay in the top.
- A thin top aoi_sweep_top connects this block to an and_or_invert_4inputs instance for on-chip self-test.

## Test plan
- Healthy gate model, SETTLE_CYCLES=2: start pulse → aoi vectors 0000..1111 in order, each held 3 cycles. done pulses 48 cycles after E0; pass=1, err_count=0, fail_valid=0.
- Gate stuck-at-1 output: one sweep → err_count=7 (vectors 0011, 0111, 1011, 1100..1111), first_fail_vec=4'b0011, pass=0.
- Gate modelled as ~(a&b) only, dropping the c&d term: err_count=3, first_fail_vec=4'b0011, pass=0.
- Reset asserted at vector 9 mid-sweep, then released → all outputs 0 immediately (asynchronous). A new start yields a full clean 16-vector sweep with pass=1.
- start re-pulsed during SETTLE of vector 5 and again in the DONE cycle → ignored; exactly one done pulse per accepted start. Vector order is unaffected.
- SETTLE_CYCLES=1 with a gate that has 1-cycle output delay → done after 32 cycles, pass=1. Same gate with 2-cycle delay and SETTLE_CYCLES=1 → nonzero err_count.

Source files
------------

// File: rtl/aoi_ctrl_pkg.sv
// Shared definitions for the AOI sweep self-test controller.
// Contents:
//   VEC_COUNT / VEC_W / ERR_W / WAIT_W - sweep sizing constants
//   aoi_state_e                        - controller FSM state encoding (2 bits)
//   aoi_golden()                       - reference function ~((a&b)|(c&d)), vec = {a,b,c,d}
package aoi_ctrl_pkg;

    localparam int unsigned VEC_COUNT = 16;
    localparam int unsigned VEC_W     = 4;
    localparam int unsigned ERR_W     = 5;   // holds 0..16
    localparam int unsigned WAIT_W    = 4;   // settle counter, SETTLE_CYCLES up to 15

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } aoi_state_e;

    // Expected output of the and-or-invert gate for vector {a,b,c,d}.
    function automatic logic aoi_golden(input logic [VEC_W-1:0] vec);
        return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    endfunction

endpackage

// File: rtl/and_or_invert_4inputs.sv
// Four-input and-or-invert gate: y_o = ~((a_i & b_i) | (c_i & d_i)).
// Ports: a_i, b_i, c_i, d_i - gate inputs; y_o - gate output.
module and_or_invert_4inputs (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    output logic y_o
);

    assign y_o = ~((a_i & b_i) | (c_i & d_i));

endmodule

// File: rtl/aoi_sweep_counter.sv
// Vector and settle-wait counters for the AOI sweep.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   clear_i       - zero both vec and wait counter (start of sweep)
//   wait_en_i     - count a settle cycle; wraps to 0 on the last settle cycle
//   vec_step_i    - advance to the next vector; holds at the last vector (no wrap)
//   vec_o         - current vector {a,b,c,d}
//   wait_last_o   - this is the final settle cycle for the current vector
//   vec_last_o    - current vector is the last one of the sweep
module aoi_sweep_counter
    import aoi_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             wait_en_i,
    input  logic             vec_step_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             wait_last_o,
    output logic             vec_last_o
);

    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]  VecLast  = VEC_W'(VEC_COUNT - 1);

    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign wait_last_o = (wait_q == WaitLast);
    assign vec_last_o  = (vec_q == VecLast);
    assign vec_o       = vec_q;

    always_comb begin
        vec_d  = vec_q;
        wait_d = wait_q;
        if (clear_i) begin
            vec_d  = '0;
            wait_d = '0;
        end else begin
            if (wait_en_i) begin
                wait_d = wait_last_o ? '0 : wait_q + WAIT_W'(1);
            end
            if (vec_step_i && !vec_last_o) begin
                vec_d = vec_q + VEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vec_q  <= '0;
            wait_q <= '0;
        end else begin
            vec_q  <= vec_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/aoi_sweep_top.sv
// On-chip self-test wrapper: sweep controller driving a local AOI gate instance.
// Ports: clk, rst, start in; busy, done, pass, err_count, fail_valid,
// first_fail_vec out (same meaning as on aoi_sweep_controller).
module aoi_sweep_top
    import aoi_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);

    logic gate_a, gate_b, gate_c, gate_d, gate_y;

    aoi_sweep_controller #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .aoi_out        (gate_y),
        .aoi_a          (gate_a),
        .aoi_b          (gate_b),
        .aoi_c          (gate_c),
        .aoi_d          (gate_d),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .fail_valid     (fail_valid),
        .first_fail_vec (first_fail_vec)
    );

    and_or_invert_4inputs u_gate (
        .a_i (gate_a),
        .b_i (gate_b),
        .c_i (gate_c),
        .d_i (gate_d),
        .y_o (gate_y)
    );

endmodule

// File: rtl/aoi_sweep_controller.sv
// Built-in self-test sequencer for an external 4-input and-or-invert gate.
// Walks all 16 input vectors in ascending order, holds each for SETTLE_CYCLES,
// samples the gate output and scores it against aoi_golden().
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - one-cycle run request, accepted only when idle
//   aoi_out         - output of the gate under test
//   aoi_a..aoi_d    - vector bits to the gate (registered, glitch-free)
//   busy            - sweep in progress (SETTLE, SAMPLE, DONE)
//   done            - one-cycle pulse at end of sweep
//   pass            - last completed sweep had no mismatches
//   err_count       - mismatch count, saturating at 16
//   fail_valid      - at least one mismatch recorded
//   first_fail_vec  - vector of the first mismatch (0 if none)
module aoi_sweep_controller
    import aoi_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             aoi_out,
    output logic             aoi_a,
    output logic             aoi_b,
    output logic             aoi_c,
    output logic             aoi_d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);

    localparam logic [ERR_W-1:0] ErrMax = ERR_W'(VEC_COUNT);

    aoi_state_e state_q, state_d;

    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0] first_fail_vec_q, first_fail_vec_d;
    logic             pass_q, pass_d;

    logic             cnt_clear;
    logic             cnt_wait_en;
    logic             cnt_vec_step;
    logic [VEC_W-1:0] vec;
    logic             wait_last;
    logic             vec_last;
    logic             mismatch;

    aoi_sweep_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_counter (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (cnt_clear),
        .wait_en_i   (cnt_wait_en),
        .vec_step_i  (cnt_vec_step),
        .vec_o       (vec),
        .wait_last_o (wait_last),
        .vec_last_o  (vec_last)
    );

    // aoi_out only feeds next-state logic, so no combinational path reaches an output.
    assign mismatch = (aoi_out != aoi_golden(vec));

    always_comb begin
        state_d          = state_q;
        err_count_d      = err_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;
        pass_d           = pass_q;
        cnt_clear        = 1'b0;
        cnt_wait_en      = 1'b0;
        cnt_vec_step     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_clear        = 1'b1;
                    err_count_d      = '0;
                    fail_valid_d     = 1'b0;
                    first_fail_vec_d = '0;
                    pass_d           = 1'b0;
                    state_d          = StSettle;
                end
            end
            StSettle: begin
                cnt_wait_en = 1'b1;
                if (wait_last) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (mismatch) begin
                    if (err_count_q != ErrMax) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d     = 1'b1;
                        first_fail_vec_d = vec;
                    end
                end
                if (vec_last) begin
                    state_d = StDone;
                end else begin
                    cnt_vec_step = 1'b1;
                    state_d      = StSettle;
                end
            end
            StDone: begin
                // err_count_q already includes the final comparison here.
                pass_d  = (err_count_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            err_count_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= '0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            err_count_q      <= err_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
            pass_q           <= pass_d;
        end
    end

    assign {aoi_a, aoi_b, aoi_c, aoi_d} = vec;

    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_vec_q;

endmodule
